// File: rtl/ntm_convolutional_fnn_scheduler.sv
// ntm_convolutional_fnn_scheduler
//
// Purpose: sequences one convolutional FNN controller pass,
//   h(l) = sum_j W(l,j)*x(j) + sum_{i,k} K(i,l,k)*r(i,k) + b(l),
// for l = 0 .. size_l-1. Operands are fetched one pair at a time over a
// request/valid port. Each pair goes through a single shared external
// multiplier, and the products are accumulated here. Every finished h(l) is
// streamed out with a one-cycle strobe.
//
// Optional feature: define NTM_CONV_FNN_SATURATE_EN to make every accumulate
// (products and bias) saturate at the signed DATA_SIZE limits. Without it,
// the accumulator wraps modulo 2^DATA_SIZE.
//
// Ports:
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   start                       begin a pass (only honoured in IDLE)
//   ready                       one-cycle pulse when the pass is complete
//   size_x_in/size_r_in/
//   size_w_in/size_l_in         runtime dimensions, latched at start, clamped to X/R/W/L
//   op_req                      operand request, held until op_valid
//   op_sel                      0 = W*x, 1 = K*r, 2 = bias
//   op_i/op_j/op_l              indices: sel0 (-,j,l); sel1 (i,k,l); sel2 (-,-,l)
//   op_valid, op_a_in, op_b_in  operand response (may arrive in the request cycle)
//   mul_start                   one-cycle multiply start
//   mul_a_out, mul_b_out        operands for the external multiplier
//   mul_ready, mul_data_in      product handshake from the multiplier
//   h_out_enable                one-cycle strobe: h_out/h_l_out are valid
//   h_out, h_l_out              result and its output index (held until next strobe)

module ntm_convolutional_fnn_scheduler #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int X            = 64,
  parameter int R            = 64,
  parameter int W            = 64,
  parameter int L            = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    ready,
  input  logic [CONTROL_SIZE-1:0] size_x_in,
  input  logic [CONTROL_SIZE-1:0] size_r_in,
  input  logic [CONTROL_SIZE-1:0] size_w_in,
  input  logic [CONTROL_SIZE-1:0] size_l_in,
  output logic                    op_req,
  output logic [1:0]              op_sel,
  output logic [CONTROL_SIZE-1:0] op_i,
  output logic [CONTROL_SIZE-1:0] op_j,
  output logic [CONTROL_SIZE-1:0] op_l,
  input  logic                    op_valid,
  input  logic [DATA_SIZE-1:0]    op_a_in,
  input  logic [DATA_SIZE-1:0]    op_b_in,
  output logic                    mul_start,
  output logic [DATA_SIZE-1:0]    mul_a_out,
  output logic [DATA_SIZE-1:0]    mul_b_out,
  input  logic                    mul_ready,
  input  logic [DATA_SIZE-1:0]    mul_data_in,
  output logic                    h_out_enable,
  output logic [DATA_SIZE-1:0]    h_out,
  output logic [CONTROL_SIZE-1:0] h_l_out
);

  localparam logic [CONTROL_SIZE-1:0] X_MAX = CONTROL_SIZE'(X);
  localparam logic [CONTROL_SIZE-1:0] R_MAX = CONTROL_SIZE'(R);
  localparam logic [CONTROL_SIZE-1:0] W_MAX = CONTROL_SIZE'(W);
  localparam logic [CONTROL_SIZE-1:0] L_MAX = CONTROL_SIZE'(L);
  localparam logic [CONTROL_SIZE-1:0] ONE_C = CONTROL_SIZE'(1);

  localparam logic [1:0] SEL_WX   = 2'd0;
  localparam logic [1:0] SEL_KR   = 2'd1;
  localparam logic [1:0] SEL_BIAS = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_MUL_ISSUE,
    S_MUL_WAIT,
    S_ACC,
    S_BIAS_FETCH,
    S_BIAS_ACC,
    S_EMIT,
    S_DONE
  } state_t;

  state_t                  state_reg, state_next;
  logic [CONTROL_SIZE-1:0] size_x_reg, size_x_next;
  logic [CONTROL_SIZE-1:0] size_r_reg, size_r_next;
  logic [CONTROL_SIZE-1:0] size_w_reg, size_w_next;
  logic [CONTROL_SIZE-1:0] size_l_reg, size_l_next;
  logic [1:0]              sel_reg, sel_next;
  logic [CONTROL_SIZE-1:0] i_reg, i_next;
  logic [CONTROL_SIZE-1:0] j_reg, j_next;
  logic [CONTROL_SIZE-1:0] k_reg, k_next;
  logic [CONTROL_SIZE-1:0] l_reg, l_next;
  logic [DATA_SIZE-1:0]    acc_reg, acc_next;
  logic [DATA_SIZE-1:0]    prod_reg, prod_next;
  logic [DATA_SIZE-1:0]    bias_reg, bias_next;
  logic [DATA_SIZE-1:0]    mul_a_reg, mul_a_next;
  logic [DATA_SIZE-1:0]    mul_b_reg, mul_b_next;
  logic [DATA_SIZE-1:0]    h_out_reg, h_out_next;
  logic [CONTROL_SIZE-1:0] h_l_reg, h_l_next;

  logic [CONTROL_SIZE-1:0] size_x_clamped;
  logic [CONTROL_SIZE-1:0] size_r_clamped;
  logic [CONTROL_SIZE-1:0] size_w_clamped;
  logic [CONTROL_SIZE-1:0] size_l_clamped;
  logic [DATA_SIZE-1:0]    bias_sum;

  function automatic logic [CONTROL_SIZE-1:0] clamp_size(
    input logic [CONTROL_SIZE-1:0] value,
    input logic [CONTROL_SIZE-1:0] max_value
  );
    return (value > max_value) ? max_value : value;
  endfunction

  // First non-empty phase of an output: W*x if there is any input, else
  // K*r if both read dimensions are non-zero, else straight to the bias.
  function automatic logic [1:0] first_sel(
    input logic [CONTROL_SIZE-1:0] sx,
    input logic [CONTROL_SIZE-1:0] sr,
    input logic [CONTROL_SIZE-1:0] sw
  );
    if (sx != '0)
      return SEL_WX;
    else if ((sr != '0) && (sw != '0))
      return SEL_KR;
    else
      return SEL_BIAS;
  endfunction

`ifdef NTM_CONV_FNN_SATURATE_EN
  localparam logic [DATA_SIZE-1:0] ACC_MAX = {1'b0, {(DATA_SIZE-1){1'b1}}};
  localparam logic [DATA_SIZE-1:0] ACC_MIN = {1'b1, {(DATA_SIZE-1){1'b0}}};

  // Signed overflow happens only when both addends share a sign and the
  // sum's sign differs; the addends' sign then says which limit to pin to.
  function automatic logic [DATA_SIZE-1:0] acc_add(
    input logic [DATA_SIZE-1:0] a,
    input logic [DATA_SIZE-1:0] b
  );
    logic [DATA_SIZE-1:0] s;
    s = a + b;
    if ((a[DATA_SIZE-1] == b[DATA_SIZE-1]) && (s[DATA_SIZE-1] != a[DATA_SIZE-1]))
      s = a[DATA_SIZE-1] ? ACC_MIN : ACC_MAX;
    return s;
  endfunction
`else
  function automatic logic [DATA_SIZE-1:0] acc_add(
    input logic [DATA_SIZE-1:0] a,
    input logic [DATA_SIZE-1:0] b
  );
    return a + b;
  endfunction
`endif

  assign size_x_clamped = clamp_size(size_x_in, X_MAX);
  assign size_r_clamped = clamp_size(size_r_in, R_MAX);
  assign size_w_clamped = clamp_size(size_w_in, W_MAX);
  assign size_l_clamped = clamp_size(size_l_in, L_MAX);

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      size_x_reg <= '0;
      size_r_reg <= '0;
      size_w_reg <= '0;
      size_l_reg <= '0;
      sel_reg    <= SEL_WX;
      i_reg      <= '0;
      j_reg      <= '0;
      k_reg      <= '0;
      l_reg      <= '0;
      acc_reg    <= '0;
      prod_reg   <= '0;
      bias_reg   <= '0;
      mul_a_reg  <= '0;
      mul_b_reg  <= '0;
      h_out_reg  <= '0;
      h_l_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      size_x_reg <= size_x_next;
      size_r_reg <= size_r_next;
      size_w_reg <= size_w_next;
      size_l_reg <= size_l_next;
      sel_reg    <= sel_next;
      i_reg      <= i_next;
      j_reg      <= j_next;
      k_reg      <= k_next;
      l_reg      <= l_next;
      acc_reg    <= acc_next;
      prod_reg   <= prod_next;
      bias_reg   <= bias_next;
      mul_a_reg  <= mul_a_next;
      mul_b_reg  <= mul_b_next;
      h_out_reg  <= h_out_next;
      h_l_reg    <= h_l_next;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_next  = state_reg;
    size_x_next = size_x_reg;
    size_r_next = size_r_reg;
    size_w_next = size_w_reg;
    size_l_next = size_l_reg;
    sel_next    = sel_reg;
    i_next      = i_reg;
    j_next      = j_reg;
    k_next      = k_reg;
    l_next      = l_reg;
    acc_next    = acc_reg;
    prod_next   = prod_reg;
    bias_next   = bias_reg;
    mul_a_next  = mul_a_reg;
    mul_b_next  = mul_b_reg;
    h_out_next  = h_out_reg;
    h_l_next    = h_l_reg;
    bias_sum    = acc_add(acc_reg, bias_reg);

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          size_x_next = size_x_clamped;
          size_r_next = size_r_clamped;
          size_w_next = size_w_clamped;
          size_l_next = size_l_clamped;
          i_next      = '0;
          j_next      = '0;
          k_next      = '0;
          l_next      = '0;
          acc_next    = '0;
          if (size_l_clamped == '0) begin
            state_next = S_DONE;
          end else begin
            sel_next   = first_sel(size_x_clamped, size_r_clamped, size_w_clamped);
            state_next = (sel_next == SEL_BIAS) ? S_BIAS_FETCH : S_FETCH;
          end
        end
      end

      S_FETCH: begin
        if (op_valid) begin
          mul_a_next = op_a_in;
          mul_b_next = op_b_in;
          state_next = S_MUL_ISSUE;
        end
      end

      S_MUL_ISSUE: begin
        state_next = S_MUL_WAIT;
      end

      S_MUL_WAIT: begin
        if (mul_ready) begin
          prod_next  = mul_data_in;
          state_next = S_ACC;
        end
      end

      S_ACC: begin
        acc_next = acc_add(acc_reg, prod_reg);
        if (sel_reg == SEL_WX) begin
          if ((j_reg + ONE_C) < size_x_reg) begin
            j_next     = j_reg + ONE_C;
            state_next = S_FETCH;
          end else begin
            j_next = '0;
            if ((size_r_reg != '0) && (size_w_reg != '0)) begin
              sel_next   = SEL_KR;
              i_next     = '0;
              k_next     = '0;
              state_next = S_FETCH;
            end else begin
              sel_next   = SEL_BIAS;
              state_next = S_BIAS_FETCH;
            end
          end
        end else begin
          // K*r phase: k is the inner loop, i the outer loop.
          if ((k_reg + ONE_C) < size_w_reg) begin
            k_next     = k_reg + ONE_C;
            state_next = S_FETCH;
          end else begin
            k_next = '0;
            if ((i_reg + ONE_C) < size_r_reg) begin
              i_next     = i_reg + ONE_C;
              state_next = S_FETCH;
            end else begin
              i_next     = '0;
              sel_next   = SEL_BIAS;
              state_next = S_BIAS_FETCH;
            end
          end
        end
      end

      S_BIAS_FETCH: begin
        if (op_valid) begin
          bias_next  = op_a_in;
          state_next = S_BIAS_ACC;
        end
      end

      S_BIAS_ACC: begin
        // The result register is loaded here so it is already valid during
        // the EMIT strobe cycle, and then simply holds afterwards.
        acc_next   = bias_sum;
        h_out_next = bias_sum;
        h_l_next   = l_reg;
        state_next = S_EMIT;
      end

      S_EMIT: begin
        acc_next = '0;
        l_next   = l_reg + ONE_C;
        if ((l_reg + ONE_C) >= size_l_reg) begin
          state_next = S_DONE;
        end else begin
          sel_next   = first_sel(size_x_reg, size_r_reg, size_w_reg);
          state_next = (sel_next == SEL_BIAS) ? S_BIAS_FETCH : S_FETCH;
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Moore outputs: all decode from registered state, so they are 0 in reset.
  assign op_req       = (state_reg == S_FETCH) || (state_reg == S_BIAS_FETCH);
  assign op_sel       = sel_reg;
  assign op_i         = i_reg;
  assign op_j         = (sel_reg == SEL_KR) ? k_reg : j_reg;
  assign op_l         = l_reg;
  assign mul_start    = (state_reg == S_MUL_ISSUE);
  assign mul_a_out    = mul_a_reg;
  assign mul_b_out    = mul_b_reg;
  assign h_out_enable = (state_reg == S_EMIT);
  assign h_out        = h_out_reg;
  assign h_l_out      = h_l_reg;
  assign ready        = (state_reg == S_DONE);

endmodule

// File: tb/tb_ntm_convolutional_fnn_scheduler.sv
// Self-checking bench for ntm_convolutional_fnn_scheduler.
//
// The bench provides an operand memory responder and a multiplier responder,
// each with a programmable delay. Every pass queues its expected (h, l)
// results and READY latency. A negedge monitor pops those expectations when
// the DUT strobes, so the stimulus and the checks run independently.

module tb_ntm_convolutional_fnn_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        ready;
  logic [63:0] size_x, size_r, size_w, size_l;
  logic        op_req;
  logic [1:0]  op_sel;
  logic [63:0] op_i, op_j, op_l;
  logic        op_valid;
  logic [63:0] op_a_in, op_b_in;
  logic        mul_start;
  logic [63:0] mul_a_out, mul_b_out;
  logic        mul_ready;
  logic [63:0] mul_data_in;
  logic        h_out_enable;
  logic [63:0] h_out;
  logic [63:0] h_l_out;

  always #5 clk = ~clk;

  ntm_convolutional_fnn_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .ready        (ready),
    .size_x_in    (size_x),
    .size_r_in    (size_r),
    .size_w_in    (size_w),
    .size_l_in    (size_l),
    .op_req       (op_req),
    .op_sel       (op_sel),
    .op_i         (op_i),
    .op_j         (op_j),
    .op_l         (op_l),
    .op_valid     (op_valid),
    .op_a_in      (op_a_in),
    .op_b_in      (op_b_in),
    .mul_start    (mul_start),
    .mul_a_out    (mul_a_out),
    .mul_b_out    (mul_b_out),
    .mul_ready    (mul_ready),
    .mul_data_in  (mul_data_in),
    .h_out_enable (h_out_enable),
    .h_out        (h_out),
    .h_l_out      (h_l_out)
  );

  // ---------------- operand memories and responders ----------------
  logic [63:0] w_mem [4][4];
  logic [63:0] x_mem [4];
  logic [63:0] k_mem [4][4][4];
  logic [63:0] r_mem [4][4];
  logic [63:0] b_mem [4];

  int op_delay;
  int mul_delay;
  int op_cnt;
  int mul_cnt;
  logic mul_busy;
  logic [63:0] prod_q;
  int cyc;

  always_comb begin
    op_a_in = '0;
    op_b_in = '0;
    case (op_sel)
      2'd0: begin
        op_a_in = w_mem[op_l[1:0]][op_j[1:0]];
        op_b_in = x_mem[op_j[1:0]];
      end
      2'd1: begin
        op_a_in = k_mem[op_i[1:0]][op_l[1:0]][op_j[1:0]];
        op_b_in = r_mem[op_i[1:0]][op_j[1:0]];
      end
      default: op_a_in = b_mem[op_l[1:0]];
    endcase
  end

  assign op_valid    = op_req && (op_cnt == op_delay);
  assign mul_ready   = mul_busy && (mul_cnt == mul_delay);
  assign mul_data_in = prod_q;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      op_cnt   <= 0;
      mul_busy <= 1'b0;
      mul_cnt  <= 0;
      prod_q   <= '0;
    end else begin
      if (op_req && !op_valid) op_cnt <= op_cnt + 1;
      else                     op_cnt <= 0;
      if (mul_start) begin
        mul_busy <= 1'b1;
        mul_cnt  <= 0;
        prod_q   <= mul_a_out * mul_b_out;
      end else if (mul_busy) begin
        if (mul_ready) mul_busy <= 1'b0;
        else           mul_cnt  <= mul_cnt + 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [63:0] exp_h_q [$];
  logic [63:0] exp_l_q [$];
  int          exp_lat_q [$];
  int          t0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_ready = 0;
  int          exp_ready_total = 0;
  int          proto_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  logic        prev_req, prev_valid, prev_ms;
  logic [1:0]  prev_sel;
  logic [63:0] prev_i, prev_j, prev_l;

  always @(negedge clk) begin
    logic [63:0] eh, el;
    int lat;
    if (rst_n) begin
      if (h_out_enable) begin
        if (exp_h_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_strobe: actual h_out 0x%0h l %0d, required no strobe", h_out, h_l_out);
        end else begin
          eh = exp_h_q.pop_front();
          el = exp_l_q.pop_front();
          chk("h_out", h_out, eh);
          chk("h_l_out", h_l_out, el);
          $display("strobe: h_out=0x%0h l=%0d (expected 0x%0h l=%0d)", h_out, h_l_out, eh, el);
        end
      end
      if (ready) begin
        n_ready++;
        if (exp_lat_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ready: actual ready at cycle %0d, required none", cyc);
        end else begin
          lat = exp_lat_q.pop_front();
          if (lat >= 0) chk("ready_latency", 64'(cyc - t0), 64'(lat));
          chk("pending_strobes_at_ready", 64'(exp_h_q.size()), 64'd0);
          $display("ready: latency=%0d (expected %0d)", cyc - t0, lat);
        end
      end
      // Operands and indices must stay put while a request is outstanding,
      // and a multiply start must never last more than one cycle.
      if (prev_req && !prev_valid &&
          (!op_req || op_sel != prev_sel || op_i != prev_i || op_j != prev_j || op_l != prev_l))
        proto_err++;
      if (prev_ms && mul_start) proto_err++;
      prev_req   <= op_req;
      prev_valid <= op_valid;
      prev_ms    <= mul_start;
      prev_sel   <= op_sel;
      prev_i     <= op_i;
      prev_j     <= op_j;
      prev_l     <= op_l;
    end else begin
      prev_req   <= 1'b0;
      prev_valid <= 1'b0;
      prev_ms    <= 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_mem();
    for (int a = 0; a < 4; a++) begin
      x_mem[a] = '0;
      b_mem[a] = '0;
      for (int b = 0; b < 4; b++) begin
        w_mem[a][b] = '0;
        r_mem[a][b] = '0;
        for (int c = 0; c < 4; c++) k_mem[a][b][c] = '0;
      end
    end
  endtask

  task automatic expect_h(input logic [63:0] h, input logic [63:0] l);
    exp_h_q.push_back(h);
    exp_l_q.push_back(l);
  endtask

  task automatic run_pass(input int sx, input int sr, input int sw, input int sl, input int lat);
    @(negedge clk);
    size_x = 64'(sx);
    size_r = 64'(sr);
    size_w = 64'(sw);
    size_l = 64'(sl);
    start  = 1'b1;
    t0     = cyc;
    exp_lat_q.push_back(lat);
    exp_ready_total++;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    int seen;
    int c;
    seen = n_ready;
    c = 0;
    while (c < budget && n_ready == seen) begin
      @(negedge clk);
      c++;
    end
    if (n_ready == seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: actual no ready after %0d cycles, required one", budget);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic load_basic();
    clear_mem();
    w_mem[0][0] = 64'd1;
    w_mem[0][1] = 64'd4;
    x_mem[0]    = 64'd2;
    x_mem[1]    = 64'd3;
    k_mem[0][0][0] = 64'd5;
    r_mem[0][0] = 64'd1;
    b_mem[0]    = 64'd7;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: actual simulation still running, required finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int c;
    rst_n = 1'b0;
    start = 1'b0;
    size_x = '0; size_r = '0; size_w = '0; size_l = '0;
    op_delay = 0;
    mul_delay = 0;
    cyc = 0;
    clear_mem();
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_op_req", 64'(op_req), 64'd0);
    chk("reset_mul_start", 64'(mul_start), 64'd0);
    chk("reset_h_out_enable", 64'(h_out_enable), 64'd0);
    chk("reset_h_out", h_out, 64'd0);
    chk("reset_h_l_out", h_l_out, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic: 1*2 + 4*3 + 5*1 + 7 = 26, three product terms -> READY at 16.
    load_basic();
    expect_h(64'd26, 64'd0);
    run_pass(2, 1, 1, 1, 16);
    wait_ready(100);

    // Multi-output: W(l,0)=l+1, x=10 -> 10,20,30; 3*(4+2+1)+1 = 22.
    clear_mem();
    w_mem[0][0] = 64'd1; w_mem[1][0] = 64'd2; w_mem[2][0] = 64'd3;
    x_mem[0] = 64'd10;
    expect_h(64'd10, 64'd0);
    expect_h(64'd20, 64'd1);
    expect_h(64'd30, 64'd2);
    run_pass(1, 0, 1, 3, 22);
    wait_ready(100);

    // Backpressure: each term 4 fetch + 1 issue + 6 wait + 1 acc = 12,
    // bias 4 + 1, emit 1, done 1 -> 3*12 + 5 + 1 + 1 = 43.
    load_basic();
    op_delay = 3;
    mul_delay = 5;
    expect_h(64'd26, 64'd0);
    run_pass(2, 1, 1, 1, 43);
    wait_ready(200);
    op_delay = 0;
    mul_delay = 0;

    // Bias only: h = 9, latency 4.
    clear_mem();
    b_mem[0] = 64'd9;
    expect_h(64'd9, 64'd0);
    run_pass(0, 0, 0, 1, 4);
    wait_ready(50);

    // No outputs: READY one cycle after START, no strobe.
    run_pass(2, 1, 1, 0, 1);
    wait_ready(20);

    // Convolutional terms over i and k for two outputs:
    // l0: 1*3 + (1*5+2*6+3*7+4*8) + 1 = 74 ; l1: 2*3 + 10*70 + 2 = 708.
    clear_mem();
    w_mem[0][0] = 64'd1;
    w_mem[1][0] = 64'd2;
    x_mem[0] = 64'd3;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 2; k++) begin
        k_mem[i][0][k] = 64'(2 * i + k + 1);
        k_mem[i][1][k] = 64'(10 * (2 * i + k + 1));
        r_mem[i][k]    = 64'(5 + 2 * i + k);
      end
    end
    b_mem[0] = 64'd1;
    b_mem[1] = 64'd2;
    expect_h(64'd74, 64'd0);
    expect_h(64'd708, 64'd1);
    run_pass(1, 2, 2, 2, 47);
    wait_ready(200);

    // Negative operands: -3*5 + 4 = -11.
    clear_mem();
    w_mem[0][0] = 64'hFFFF_FFFF_FFFF_FFFD;
    x_mem[0] = 64'd5;
    b_mem[0] = 64'd4;
    expect_h(64'hFFFF_FFFF_FFFF_FFF5, 64'd0);
    run_pass(1, 0, 0, 1, 8);
    wait_ready(50);

    // Clamp: size_x 100 clamps to 64 ones -> 64; 64*4 + 3 + 1 = 260.
    clear_mem();
    for (int a = 0; a < 4; a++) begin
      x_mem[a] = 64'd1;
      for (int b = 0; b < 4; b++) w_mem[a][b] = 64'd1;
    end
    expect_h(64'd64, 64'd0);
    run_pass(100, 0, 0, 1, 260);
    wait_ready(400);

    // Overflow: 2^62 + 2^62 wraps to 0x8000.. or saturates to 0x7FFF...
    clear_mem();
    w_mem[0][0] = 64'h2000_0000_0000_0000;
    w_mem[0][1] = 64'h2000_0000_0000_0000;
    x_mem[0] = 64'd2;
    x_mem[1] = 64'd2;
`ifdef NTM_CONV_FNN_SATURATE_EN
    expect_h(64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
`else
    expect_h(64'h8000_0000_0000_0000, 64'd0);
`endif
    run_pass(2, 0, 0, 1, 12);
    wait_ready(50);

    // START pulsed while busy is ignored: one READY, unchanged latency.
    load_basic();
    expect_h(64'd26, 64'd0);
    run_pass(2, 1, 1, 1, 16);
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_ready(100);
    repeat (20) @(negedge clk);

    // Reset while waiting on the multiplier aborts the pass.
    load_basic();
    mul_delay = 5;
    expect_h(64'd26, 64'd0);
    run_pass(2, 1, 1, 1, -1);
    c = 0;
    while (c < 40 && !mul_start) begin
      @(negedge clk);
      c++;
    end
    chk("mul_start_seen", 64'(mul_start), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_h_q.delete();
    exp_l_q.delete();
    exp_lat_q.delete();
    exp_ready_total--;
    chk("abort_ready", 64'(ready), 64'd0);
    chk("abort_op_req", 64'(op_req), 64'd0);
    chk("abort_mul_start", 64'(mul_start), 64'd0);
    chk("abort_h_out_enable", 64'(h_out_enable), 64'd0);
    chk("abort_h_out", h_out, 64'd0);
    chk("abort_mul_a_out", mul_a_out, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mul_delay = 0;
    repeat (10) @(negedge clk);

    // A fresh pass after the abort behaves normally.
    expect_h(64'd26, 64'd0);
    run_pass(2, 1, 1, 1, 16);
    wait_ready(100);

    chk("protocol_violations", 64'(proto_err), 64'd0);
    chk("leftover_expectations", 64'(exp_h_q.size() + exp_lat_q.size()), 64'd0);
    chk("ready_count", 64'(n_ready), 64'(exp_ready_total));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
